muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit for the single-cycle core.
- Takes rs1/rs2 operand data read from the register file and computes the M-extension result over multiple cycles while stalling the core.
- Drives a dedicated write-back port (reg_wr/waddr/wdata) into the register file's write mux.
- The register file writes on negedge clk. This block's outputs change only on posedge, so they are stable at that write edge.

---
 rtl/muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with a registered write-back port into the register file.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      rd_addr,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic            reg_wr,
    output logic [4:0]      waddr,
    output logic [XLEN-1:0] wdata
);

    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state;
    logic [5:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] opa;
    logic [XLEN-1:0]   opb;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              neg_r;
    logic              fast;

    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, in_fast;
    logic [XLEN-1:0]   fast_val;

    // Operand decode at the accept edge: magnitudes, signs and the fast-path result.
    always_comb begin
        a_signed = op[2] ? ~op[0] : ((op == 3'b001) || (op == 3'b010));
        b_signed = op[2] ? ~op[0] : (op == 3'b001);
        a_neg    = a_signed & rs1_data[XLEN-1];
        b_neg    = b_signed & rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = (rs2_data == '0);
        div_ovf  = ~op[0] && (rs1_data == INT_MIN) && (rs2_data == '1);
        in_fast  = op[2] & (div_zero | div_ovf);
        if (!op[1])
            fast_val = div_zero ? '1 : INT_MIN;
        else
            fast_val = div_zero ? rs1_data : '0;
    end

    logic [2*XLEN-1:0] acc_mul;
    logic [XLEN:0]     r_shift;
    logic [XLEN+1:0]   diff;
    logic              fits;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, result;

    // One iteration step for each datapath, plus the sign-corrected final result.
    always_comb begin
        acc_mul = opb[0] ? (acc + opa) : acc;
        r_shift = {acc[XLEN-1:0], opa[XLEN-1]};
        diff    = {1'b0, r_shift} - {2'b00, opb};
        fits    = ~diff[XLEN+1];
        prod    = neg_q ? -acc : acc;
        quo     = neg_q ? -opa[XLEN-1:0] : opa[XLEN-1:0];
        rem     = neg_r ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        if (op_q[2])
            result = op_q[1] ? rem : quo;
        else if (op_q[1:0] == 2'b00)
            result = prod[XLEN-1:0];
        else
            result = prod[2*XLEN-1:XLEN];
    end

    // The extra CALC cycle at count == ITERS applies the sign fix and loads wdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            count <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            op_q  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            fast  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start && !done && !flush) begin
                        state <= CALC;
                        busy  <= 1'b1;
                        count <= '0;
                        op_q  <= op;
                        waddr <= rd_addr;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        fast  <= in_fast;
                        opa   <= {{XLEN{1'b0}}, a_mag};
                        opb   <= b_mag;
                        acc   <= in_fast ? {{XLEN{1'b0}}, fast_val} : '0;
                    end
                end
                CALC: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (fast) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        wdata <= acc[XLEN-1:0];
                    end else if (count == 6'(ITERS)) begin
                        state <= FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        wdata <= result;
                    end else begin
                        count <= count + 6'd1;
                        if (op_q[2]) begin
                            acc <= {{(XLEN-1){1'b0}}, (fits ? diff[XLEN:0] : r_shift)};
                            opa <= {{XLEN{1'b0}}, opa[XLEN-2:0], fits};
                        end else begin
                            acc <= acc_mul;
                            opa <= opa << 1;
                            opb <= opb >> 1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    assign reg_wr = done & (waddr != 5'd0);
    assign stall  = (start & ~done) | busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: latency, results, fast paths,
// x0 suppression, flush and asynchronous reset aborts.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rd_addr;
    logic        flush;
    logic        busy, stall, done, reg_wr;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .rd_addr  (rd_addr),
        .flush    (flush),
        .busy     (busy),
        .stall    (stall),
        .done     (done),
        .reg_wr   (reg_wr),
        .waddr    (waddr),
        .wdata    (wdata)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one operation with start held, then track it to its done pulse.
    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd,
                                 input logic [31:0] exp_data, input int exp_lat);
        int cycles;
        int busy_cycles;
        @(negedge clk);
        op       = o;
        rs1_data = a;
        rs2_data = b;
        rd_addr  = rd;
        start    = 1'b1;
        #1;
        checkOutput({tag, "_stall_req"}, 32'(stall), 32'd1);
        @(posedge clk);
        cycles      = 0;
        busy_cycles = 0;
        @(negedge clk);
        rs1_data = ~a;
        rs2_data = a ^ 32'h5A5A_0F0F;
        forever begin
            cycles++;
            if (done || cycles > 100) break;
            if (busy) busy_cycles++;
            @(negedge clk);
        end
        #1;
        checkOutput({tag, "_done"},    32'(done),    32'd1);
        checkOutput({tag, "_latency"}, 32'(cycles),  32'(exp_lat));
        checkOutput({tag, "_busy_len"},32'(busy_cycles), 32'(exp_lat - 1));
        checkOutput({tag, "_wdata"},   wdata,        exp_data);
        checkOutput({tag, "_waddr"},   32'(waddr),   32'(rd));
        checkOutput({tag, "_reg_wr"},  32'(reg_wr),  32'(rd != 5'd0));
        checkOutput({tag, "_stall"},   32'(stall),   32'd0);
        checkOutput({tag, "_busy"},    32'(busy),    32'd0);
    endtask

    initial begin
        int done_seen;
        reset    = 1'b1;
        start    = 1'b0;
        op       = 3'b000;
        rs1_data = '0;
        rs2_data = '0;
        rd_addr  = '0;
        flush    = 1'b0;
        #12;
        checkOutput("rst_busy",   32'(busy),   32'd0);
        checkOutput("rst_done",   32'(done),   32'd0);
        checkOutput("rst_reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("rst_waddr",  32'(waddr),  32'd0);
        checkOutput("rst_wdata",  wdata,       32'd0);
        checkOutput("rst_stall",  32'(stall),  32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("mul",    3'b000, 32'd7,          32'd6,          5'd5, 32'h0000_002A, 34);
        start = 1'b0;
        applyStimulus("mulh",   3'b001, 32'hFFFF_FFFE,  32'd3,          5'd6, 32'hFFFF_FFFF, 34);
        start = 1'b0;
        applyStimulus("mulhu",  3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd7, 32'hFFFF_FFFE, 34);
        start = 1'b0;
        applyStimulus("div",    3'b100, 32'hFFFF_FFF9,  32'd2,          5'd8, 32'hFFFF_FFFD, 34);
        start = 1'b0;
        applyStimulus("rem",    3'b110, 32'hFFFF_FFF9,  32'd2,          5'd9, 32'hFFFF_FFFF, 34);
        start = 1'b0;
        applyStimulus("divu0",  3'b101, 32'h0000_1234,  32'd0,          5'd10, 32'hFFFF_FFFF, 2);
        start = 1'b0;
        applyStimulus("remu0",  3'b111, 32'h0000_1234,  32'd0,          5'd11, 32'h0000_1234, 2);
        start = 1'b0;
        applyStimulus("divovf", 3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000, 2);
        start = 1'b0;
        applyStimulus("removf", 3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h0000_0000, 2);
        start = 1'b0;

        // x0 destination, then a start held through the done cycle must not re-issue.
        applyStimulus("mulx0",  3'b000, 32'd3,          32'd4,          5'd0, 32'h0000_000C, 34);
        op       = 3'b101;
        rs1_data = 32'd50;
        rs2_data = 32'd5;
        rd_addr  = 5'd14;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("reissue_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("reissue_done", 32'(done), 32'd0);

        // Flush mid-CALC: back to IDLE, no completion, previous result retained.
        @(negedge clk);
        op       = 3'b101;
        rs1_data = 32'd1000;
        rs2_data = 32'd3;
        rd_addr  = 5'd4;
        start    = 1'b1;
        @(posedge clk);
        repeat (20) @(negedge clk);
        checkOutput("flush_pre_busy", 32'(busy), 32'd1);
        start = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush_busy", 32'(busy), 32'd0);
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("flush_no_done", 32'(done_seen), 32'd0);
        checkOutput("flush_wdata_held", wdata, 32'h0000_000C);

        applyStimulus("divu",   3'b101, 32'd100,        32'd7,          5'd15, 32'd14, 34);
        start = 1'b0;

        // Flush in IDLE suppresses acceptance of a simultaneous start.
        @(negedge clk);
        op       = 3'b000;
        rs1_data = 32'd2;
        rs2_data = 32'd2;
        rd_addr  = 5'd3;
        start    = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        checkOutput("idle_flush_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        op       = 3'b000;
        rs1_data = 32'd5;
        rs2_data = 32'd5;
        rd_addr  = 5'd3;
        start    = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        checkOutput("areset_pre_busy", 32'(busy), 32'd1);
        start = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("areset_busy",   32'(busy),   32'd0);
        checkOutput("areset_done",   32'(done),   32'd0);
        checkOutput("areset_reg_wr", 32'(reg_wr), 32'd0);
        checkOutput("areset_waddr",  32'(waddr),  32'd0);
        checkOutput("areset_wdata",  wdata,       32'd0);
        @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        checkOutput("areset_no_done", 32'(done_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
